// File: rtl/fft_output_ctrl_if.sv
// Bundle of the three datapaths around fft_output_ctrl: sample-in stream, buffer port, line-out stream.
// Latency: none, signals only.
// Backpressure: s_ready throttles the FFT core, m_ready throttles line delivery.
interface fft_output_ctrl_if #(
  parameter int N_SAMPLES = 2048,
  parameter int SAMPLE_W  = 16,
  parameter int LINE_W    = 512
);
  localparam int SPL    = LINE_W / SAMPLE_W;
  localparam int IDX_W  = $clog2(N_SAMPLES);
  localparam int LIDX_W = $clog2(N_SAMPLES / SPL);

  // FFT core -> controller
  logic                s_valid;
  logic [SAMPLE_W-1:0] s_data;
  logic                s_ready;

  // controller <-> output buffer
  logic                buf_wr_en;
  logic [IDX_W-1:0]    buf_input_index;
  logic [SAMPLE_W-1:0] buf_data_in;
  logic [LIDX_W-1:0]   buf_output_index;
  logic [LINE_W-1:0]   buf_data_out;

  // controller -> host-write path
  logic                m_valid;
  logic [LINE_W-1:0]   m_data;
  logic                m_last;
  logic                m_ready;

  modport master (
    input  s_valid, s_data, buf_data_out, m_ready,
    output s_ready, buf_wr_en, buf_input_index, buf_data_in,
           buf_output_index, m_valid, m_data, m_last
  );

  modport slave (
    output s_valid, s_data, buf_data_out, m_ready,
    input  s_ready, buf_wr_en, buf_input_index, buf_data_in,
           buf_output_index, m_valid, m_data, m_last
  );
endinterface

// File: rtl/fft_output_ctrl.sv
// Fills the FFT output buffer with one frame of samples, then drains it as lines downstream.
// Latency: accept->buf_wr_en 1 cycle; READ->m_valid 2 cycles; 3 cycles per line when m_ready stays high.
// Backpressure: s_ready only in FILL; each line held in SEND until m_ready. FFT_OUT_ABORT_EN adds an abort input.
module fft_output_ctrl #(
  parameter int N_SAMPLES = 2048,
  parameter int SAMPLE_W  = 16,
  parameter int LINE_W    = 512
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
`ifdef FFT_OUT_ABORT_EN
  input  logic              abort,
`endif
  fft_output_ctrl_if.master bus,
  output logic              busy,
  output logic              done
);
  localparam int SPL     = LINE_W / SAMPLE_W;
  localparam int N_LINES = N_SAMPLES / SPL;
  localparam int IDX_W   = $clog2(N_SAMPLES);
  localparam int LIDX_W  = $clog2(N_LINES);

  typedef enum logic [2:0] {IDLE, FILL, READ, LATCH, SEND} state_t;

  state_t state_q, state_d;

  logic [IDX_W-1:0]    wr_cnt;
  logic [LIDX_W-1:0]   rd_cnt;
  logic                buf_wr_en_q;
  logic [IDX_W-1:0]    buf_input_index_q;
  logic [SAMPLE_W-1:0] buf_data_in_q;
  logic [LIDX_W-1:0]   buf_output_index_q;
  logic                m_valid_q;
  logic [LINE_W-1:0]   m_data_q;
  logic                m_last_q;
  logic                done_q;

  logic abort_w;
  logic s_ready_c;
  logic accept;
  logic capture;
  logic hs;
  logic clr_cnt;
  logic last_sample;
  logic last_line;

`ifdef FFT_OUT_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign last_sample = (wr_cnt == IDX_W'(N_SAMPLES - 1));
  assign last_line   = (rd_cnt == LIDX_W'(N_LINES - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and per-cycle strobes; abort overrides every transition, including the last handshake.
  always_comb begin
    state_d   = state_q;
    s_ready_c = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    hs        = 1'b0;
    clr_cnt   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FILL;
          clr_cnt = 1'b1;
        end
      end
      FILL: begin
        s_ready_c = !abort_w;
        accept    = bus.s_valid && s_ready_c;
        if (accept && last_sample) state_d = READ;
      end
      READ:  state_d = LATCH;
      LATCH: begin
        capture = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        hs = m_valid_q && bus.m_ready;
        if (hs) state_d = last_line ? IDLE : READ;
      end
      default: state_d = IDLE;
    endcase
    if (abort_w && (state_q != IDLE)) begin
      state_d = IDLE;
      clr_cnt = 1'b1;
      capture = 1'b0;
      hs      = 1'b0;
    end
  end

  // Buffer write/read sequencing, line holding register and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt             <= '0;
      rd_cnt             <= '0;
      buf_wr_en_q        <= 1'b0;
      buf_input_index_q  <= '0;
      buf_data_in_q      <= '0;
      buf_output_index_q <= '0;
      m_valid_q          <= 1'b0;
      m_data_q           <= '0;
      m_last_q           <= 1'b0;
      done_q             <= 1'b0;
    end else begin
      buf_wr_en_q <= accept;
      done_q      <= 1'b0;
      if (accept) begin
        buf_input_index_q <= wr_cnt;
        buf_data_in_q     <= bus.s_data;
        // Terminal sample leaves the counter parked instead of wrapping.
        if (!last_sample) wr_cnt <= wr_cnt + 1'b1;
        // Present line 0 during the first READ cycle.
        if (last_sample) buf_output_index_q <= '0;
      end
      if (capture) begin
        m_data_q  <= bus.buf_data_out;
        m_valid_q <= 1'b1;
        m_last_q  <= last_line;
      end
      if (hs) begin
        m_valid_q <= 1'b0;
        m_last_q  <= 1'b0;
        if (last_line) begin
          done_q <= 1'b1;
        end else begin
          rd_cnt             <= rd_cnt + 1'b1;
          buf_output_index_q <= rd_cnt + 1'b1;
        end
      end
      if (clr_cnt) begin
        wr_cnt    <= '0;
        rd_cnt    <= '0;
        m_valid_q <= 1'b0;
        m_last_q  <= 1'b0;
      end
    end
  end

  assign bus.s_ready          = s_ready_c;
  assign bus.buf_wr_en        = buf_wr_en_q;
  assign bus.buf_input_index  = buf_input_index_q;
  assign bus.buf_data_in      = buf_data_in_q;
  assign bus.buf_output_index = buf_output_index_q;
  assign bus.m_valid          = m_valid_q;
  assign bus.m_data           = m_data_q;
  assign bus.m_last           = m_last_q;
  assign busy                 = (state_q != IDLE);
  assign done                 = done_q;
endmodule

// File: tb/tb_fft_output_ctrl.sv
// Bench for fft_output_ctrl: directed frames with a buffer model and write/line scoreboards.
// Latency: checks accept->write 1 cycle and 192-cycle drain with m_ready high.
// Backpressure: stalls m_ready on lines 0, 31, 63 and toggles s_valid.
module tb_fft_output_ctrl;
  localparam int NS = 2048;
  localparam int SW = 16;
  localparam int LW = 512;

  typedef struct packed {
    logic [10:0] idx;
    logic [15:0] dat;
  } wr_t;

  logic clk;
  logic rst_n;
  logic start;
  logic busy;
  logic done;
`ifdef FFT_OUT_ABORT_EN
  logic abort;
`endif

  fft_output_ctrl_if #(.N_SAMPLES(NS), .SAMPLE_W(SW), .LINE_W(LW)) bus ();

  fft_output_ctrl #(.N_SAMPLES(NS), .SAMPLE_W(SW), .LINE_W(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
`ifdef FFT_OUT_ABORT_EN
    .abort (abort),
`endif
    .bus   (bus),
    .busy  (busy),
    .done  (done)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_wr = 0;
  int n_done = 0;
  int lines_seen = 0;
  int first_wr_cyc = 0;
  int last_wr_cyc = 0;
  int done_cyc = 0;
  logic          held = 1'b0;
  logic [LW-1:0] hold_d;
  logic          hold_l;

  logic [SW-1:0] mem [0:NS-1];
  logic [SW-1:0] exp_mem [0:NS-1];
  wr_t           wq[$];
  logic [LW-1:0] lq[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_s_ready"},   LW'(bus.s_ready),          LW'(0));
    chk({tag, "_wr_en"},     LW'(bus.buf_wr_en),        LW'(0));
    chk({tag, "_in_idx"},    LW'(bus.buf_input_index),  LW'(0));
    chk({tag, "_data_in"},   LW'(bus.buf_data_in),      LW'(0));
    chk({tag, "_out_idx"},   LW'(bus.buf_output_index), LW'(0));
    chk({tag, "_m_valid"},   LW'(bus.m_valid),          LW'(0));
    chk({tag, "_m_data"},    bus.m_data,                LW'(0));
    chk({tag, "_m_last"},    LW'(bus.m_last),           LW'(0));
    chk({tag, "_busy"},      LW'(busy),                 LW'(0));
    chk({tag, "_done"},      LW'(done),                 LW'(0));
  endtask

  // Output buffer model: indexed sample writes, registered line reads.
  always @(posedge clk) begin
    logic [LW-1:0] rl;
    if (bus.buf_wr_en) mem[bus.buf_input_index] <= bus.buf_data_in;
    for (int j = 0; j < 32; j++) rl[j*16 +: 16] = mem[{bus.buf_output_index, 5'(j)}];
    bus.buf_data_out <= rl;
  end

  // Scoreboard and hold-stability monitor.
  always @(negedge clk) begin
    wr_t we;
    logic [LW-1:0] el;
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (bus.buf_wr_en) begin
        if (n_wr == 0) first_wr_cyc = cyc;
        n_wr++;
        last_wr_cyc = cyc;
        chk("wr_q_nonempty", LW'(wq.size() != 0), LW'(1));
        if (wq.size() != 0) begin
          we = wq.pop_front();
          chk("wr_index", LW'(bus.buf_input_index), LW'(we.idx));
          chk("wr_data",  LW'(bus.buf_data_in),     LW'(we.dat));
        end
      end
      if (bus.m_valid && held) begin
        chk("hold_data", bus.m_data, hold_d);
        chk("hold_last", LW'(bus.m_last), LW'(hold_l));
      end
      if (bus.m_valid && bus.m_ready) begin
        chk("line_q_nonempty", LW'(lq.size() != 0), LW'(1));
        if (lq.size() != 0) begin
          el = lq.pop_front();
          chk("line_data", bus.m_data, el);
        end
        chk("line_last", LW'(bus.m_last), LW'(lines_seen == 63));
        lines_seen++;
        held = 1'b0;
      end else if (bus.m_valid) begin
        held   = 1'b1;
        hold_d = bus.m_data;
        hold_l = bus.m_last;
      end else begin
        held = 1'b0;
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
    end
  end

  task automatic run_frame(input int pct, input bit stalls, input bit pokes,
                           input logic [15:0] base, input int rst_at, input int abort_line);
    int   i;
    int   guard;
    int   stall_cnt;
    int   prev_lines;
    int   first_acc;
    wr_t  w;
    logic [LW-1:0] ln;
    n_wr = 0;
    n_done = 0;
    lines_seen = 0;
    first_acc = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("busy_after_start", LW'(busy), LW'(1));
    i = 0;
    guard = 0;
    while (i < NS && guard < 20000) begin
      bus.s_valid = (int'($urandom_range(99)) < pct);
      bus.s_data  = base + 16'(i);
      start       = pokes && (i >= 500) && (i < 503);
      if (i == rst_at) begin
        rst_n = 1'b0;
        bus.s_valid = 1'b0;
        start = 1'b0;
        #1;
        chk_reset_vals("mid_rst");
        wq.delete();
        lq.delete();
        repeat (2) @(negedge clk);
        chk_reset_vals("mid_rst_hold");
        @(posedge clk); #1 rst_n = 1'b1;
        return;
      end
      @(negedge clk);
      if (bus.s_valid && bus.s_ready) begin
        if (i == 0) first_acc = cyc;
        w.idx = 11'(i);
        w.dat = bus.s_data;
        wq.push_back(w);
        exp_mem[i] = bus.s_data;
        i++;
      end
      @(posedge clk); #1;
      guard++;
    end
    bus.s_valid = 1'b0;
    start = 1'b0;
    chk("fill_in_budget", LW'(guard < 20000), LW'(1));
    for (int k = 0; k < 64; k++) begin
      for (int j = 0; j < 32; j++) ln[j*16 +: 16] = exp_mem[k*32 + j];
      lq.push_back(ln);
    end
    @(negedge clk);
    chk("s_ready_after_last", LW'(bus.s_ready), LW'(0));
    @(posedge clk); #1;
    guard = 0;
    stall_cnt = 0;
    prev_lines = 0;
    while (n_done == 0 && guard < 3000) begin
      if (abort_line >= 0 && bus.m_valid && lines_seen == abort_line) begin
`ifdef FFT_OUT_ABORT_EN
        bus.m_ready = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_m_valid", LW'(bus.m_valid), LW'(0));
        chk("abort_m_last",  LW'(bus.m_last),  LW'(0));
        chk("abort_busy",    LW'(busy),        LW'(0));
        chk("abort_s_ready", LW'(bus.s_ready), LW'(0));
        repeat (4) @(negedge clk);
        chk("abort_no_done", LW'(n_done), LW'(0));
        chk("abort_idle",    LW'(busy),   LW'(0));
        lq.delete();
`endif
        return;
      end
      if (lines_seen != prev_lines) begin
        prev_lines = lines_seen;
        stall_cnt = 0;
      end
      if (stalls && bus.m_valid && (lines_seen == 0 || lines_seen == 31 || lines_seen == 63)
          && stall_cnt < 10) begin
        bus.m_ready = 1'b0;
        stall_cnt++;
      end else begin
        bus.m_ready = 1'b1;
      end
      start = pokes && bus.m_valid && (lines_seen == 10);
      @(posedge clk); #1;
      guard++;
    end
    bus.m_ready = 1'b1;
    start = 1'b0;
    chk("drain_in_budget", LW'(guard < 3000), LW'(1));
    @(negedge clk);
    chk("idle_after_done", LW'(busy), LW'(0));
    chk("done_one_cycle",  LW'(done), LW'(0));
    repeat (3) @(negedge clk);
    chk("done_count",  LW'(n_done),     LW'(1));
    chk("write_count", LW'(n_wr),       LW'(NS));
    chk("line_count",  LW'(lines_seen), LW'(64));
    chk("wq_empty",    LW'(wq.size()),  LW'(0));
    chk("lq_empty",    LW'(lq.size()),  LW'(0));
    chk("still_idle",  LW'(busy),       LW'(0));
    if (!stalls) chk("drain_cycles", LW'(done_cyc - last_wr_cyc), LW'(192));
    if (pct == 100) begin
      chk("wr_latency", LW'(first_wr_cyc - first_acc),   LW'(1));
      chk("wr_burst",   LW'(last_wr_cyc - first_wr_cyc), LW'(NS - 1));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.m_ready = 1'b1;
`ifdef FFT_OUT_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("por");
    @(posedge clk); #1 rst_n = 1'b1;

    // Full-rate frame, data = index.
    run_frame(100, 1'b0, 1'b0, 16'h0000, -1, -1);
    // About half of the cycles carry a sample.
    run_frame(50, 1'b0, 1'b0, 16'h1234, -1, -1);
    // Downstream stalls on lines 0, 31 and 63.
    run_frame(100, 1'b1, 1'b0, 16'hA000, -1, -1);
    // start pulses during FILL and SEND are ignored.
    run_frame(100, 1'b0, 1'b1, 16'h0F0F, -1, -1);
    // Reset at sample 1000, then a clean frame from index 0.
    run_frame(100, 1'b0, 1'b0, 16'h7777, 1000, -1);
    run_frame(100, 1'b0, 1'b0, 16'h5555, -1, -1);
`ifdef FFT_OUT_ABORT_EN
    // Abort in SEND at line 20, then a clean frame.
    run_frame(100, 1'b0, 1'b0, 16'h3C3C, -1, 20);
    run_frame(100, 1'b0, 1'b0, 16'h2468, -1, -1);
`endif

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
